// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point multiply-accumulate block.
//   state_t  : FSM state encoding for the controller in fixed_point_mac
//   sat_max  : largest value representable in an n-bit signed word
//   sat_min  : smallest value representable in an n-bit signed word
package fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic longint sat_max(input int n);
    return (longint'(1) <<< (n - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/fixed_point_mul_stage.sv
// Product stage: signed N x N multiply, arithmetic shift right by Q
// (floor toward minus infinity), registered one cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : load a new product this cycle (pair accepted)
//   a, b      : signed Q-format operands, N bits
//   prod      : registered shifted product, 2N-Q bits signed
//   prod_vld  : prod holds a product loaded on the previous edge
module fixed_point_mul_stage #(
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  output logic signed [2*N-Q-1:0] prod,
  output logic                  prod_vld
);

  localparam int PW = 2 * N - Q;

  logic signed [2*N-1:0] full;

  assign full = $signed(a) * $signed(b);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= en;
      // Dropping the low Q bits after an arithmetic shift floors the value.
      if (en) prod <= PW'(full >>> Q);
    end
  end

endmodule

// File: rtl/fixed_point_mac.sv
// Fixed-point multiply-accumulate: sums LEN products of signed Q-format
// operand pairs and reports the sum as an N-bit Q-format result.
// Optional feature macro: FIXED_POINT_MAC_SATURATE_EN
//   defined   -> q_result clamps to the N-bit signed limits on overflow
//   undefined -> q_result is the low N bits of the accumulator
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin an operation (honoured only in IDLE)
//   in_valid   : a/b pair present; accepted when in_ready is also high
//   a, b       : signed Q-format operands
//   in_ready   : high only while accumulating
//   busy       : high in every state except IDLE
//   out_valid  : one-cycle pulse in DONE
//   q_result   : result, held until the next operation completes
//   overflow   : final sum outside the N-bit signed range
module fixed_point_mac
  import fixed_point_pkg::*;
#(
  parameter int N   = 16,
  parameter int Q   = 12,
  parameter int LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         in_ready,
  output logic         busy,
  output logic         out_valid,
  output logic [N-1:0] q_result,
  output logic         overflow
);

  localparam int PW    = 2 * N - Q;
  localparam int ACC_W = PW + $clog2(LEN) + 1;
  localparam int CNT_W = $clog2(LEN + 1);
  localparam longint LMAX = sat_max(N);
  localparam longint LMIN = sat_min(N);

  state_t state, state_nx;

  logic                    accept;
  logic                    last;
  logic [CNT_W-1:0]        cnt;
  logic signed [PW-1:0]    prod;
  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] fin;
  longint                  fin_l;
  logic                    ovf;
  logic [N-1:0]            res;

  assign accept   = (state == ACC) && in_valid;
  assign last     = accept && (cnt == CNT_W'(LEN - 1));
  assign in_ready = (state == ACC);
  assign busy     = (state != IDLE);

  fixed_point_mul_stage #(.N(N), .Q(Q)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .en       (accept),
    .a        (a),
    .b        (b),
    .prod     (prod),
    .prod_vld (prod_vld)
  );

  // Running sum including the product currently in the product stage;
  // in DRAIN this is the final sum.
  assign fin   = acc + (prod_vld ? {{(ACC_W-PW){prod[PW-1]}}, prod} : '0);
  assign fin_l = longint'(fin);
  assign ovf   = (fin_l > LMAX) || (fin_l < LMIN);

  always_comb begin
    res = fin[N-1:0];
`ifdef FIXED_POINT_MAC_SATURATE_EN
    if (fin_l > LMAX)      res = LMAX[N-1:0];
    else if (fin_l < LMIN) res = LMIN[N-1:0];
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACC;
      ACC:     if (last)  state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      q_result  <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        ACC: begin
          acc <= fin;
          if (accept) cnt <= cnt + 1'b1;
        end
        DRAIN: begin
          acc       <= fin;
          q_result  <= res;
          overflow  <= ovf;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_mac.sv
module tb_fixed_point_mac;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] a, b;
  logic        in_ready, busy, out_valid, overflow;
  logic [15:0] q_result;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] av [8];
  logic [15:0] bv [8];

  fixed_point_mac dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .q_result  (q_result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum of floor(a*b / 2^12), then wrap or clamp to 16 bits.
  task automatic model(output logic [15:0] q, output logic ov);
    longint s;
    s = 0;
    for (int i = 0; i < 8; i++)
      s += (longint'($signed(av[i])) * longint'($signed(bv[i]))) >>> 12;
    ov = (s > 32767) || (s < -32768);
    q  = s[15:0];
`ifdef FIXED_POINT_MAC_SATURATE_EN
    if (s > 32767)       q = 16'h7FFF;
    else if (s < -32768) q = 16'h8000;
`endif
  endtask

  task automatic fill(input logic [15:0] va, input logic [15:0] vb);
    for (int i = 0; i < 8; i++) begin
      av[i] = va;
      bv[i] = vb;
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic run_op(input string tag, input int bub, input bit pulse_start);
    logic [15:0] eq;
    logic        eo;
    int          idx;
    int          guard;
    model(eq, eo);
    repeat (2) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      chk({tag, "_idle_ready"}, in_ready, 0);
      chk({tag, "_idle_busy"}, busy, 0);
    end
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_acc_busy"}, busy, 1);
    idx = 0;
    guard = 0;
    while (idx < 8) begin
      chk({tag, "_acc_ready"}, in_ready, 1);
      chk({tag, "_acc_noout"}, out_valid, 0);
      in_valid = (guard > 100) || ($urandom_range(99) >= bub);
      a = av[idx];
      b = bv[idx];
      start = pulse_start && ($urandom_range(3) == 0);
      @(negedge clk);
      if (in_valid) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_drain_out"}, out_valid, 0);
    chk({tag, "_drain_ready"}, in_ready, 0);
    chk({tag, "_drain_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_done_out"}, out_valid, 1);
    chk({tag, "_done_q"}, q_result, eq);
    chk({tag, "_done_ovf"}, overflow, eo);
    start = pulse_start;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle_out"}, out_valid, 0);
    chk({tag, "_idle_busy2"}, busy, 0);
    chk({tag, "_hold_q"}, q_result, eq);
    chk({tag, "_hold_ovf"}, overflow, eo);
    @(negedge clk);
    chk({tag, "_still_idle"}, busy, 0);
    chk({tag, "_still_q"}, q_result, eq);
  endtask

  initial begin
    logic [15:0] t1, t2;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_out", out_valid, 0);
    chk("rst_q", q_result, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    fill(16'h1000, 16'h0800);
    run_op("half", 0, 1'b0);
    chk("half_const", q_result, 16'h4000);

    fill(16'h7FFF, 16'h7FFF);
    run_op("big", 0, 1'b0);
    chk("big_ovf_const", overflow, 1);
`ifdef FIXED_POINT_MAC_SATURATE_EN
    chk("big_q_const", q_result, 16'h7FFF);
`else
    chk("big_q_const", q_result, 16'hFF80);
`endif

    fill(16'hF000, 16'h1000);
    run_op("min", 0, 1'b0);
    chk("min_q_const", q_result, 16'h8000);
    chk("min_ovf_const", overflow, 0);

    fill(16'h1000, 16'h0800);
    run_op("bubble", 40, 1'b0);
    chk("bubble_const", q_result, 16'h4000);

    run_op("startign", 30, 1'b1);

    // Reset in the middle of ACC, with start/in_valid also high.
    fill(16'h0100, 16'h0100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'h1000;
      b = 16'h0800;
      @(negedge clk);
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_out", out_valid, 0);
    chk("mid_rst_q", q_result, 0);
    chk("mid_rst_ovf", overflow, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    fill(16'h1000, 16'h0800);
    run_op("after_rst", 0, 1'b0);
    chk("after_rst_const", q_result, 16'h4000);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) begin
        t1 = 16'($urandom);
        t2 = 16'($urandom);
        if (r[0]) begin
          av[i] = {{3{t1[12]}}, t1[12:0]};
          bv[i] = {{3{t2[12]}}, t2[12:0]};
        end else begin
          av[i] = t1;
          bv[i] = t2;
        end
      end
      run_op($sformatf("rand%0d", r), 25, r[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_point_mac.md
FIXED_POINT_MAC -- requirements
Module: fixed_point_mac

Interface
REQ-001 SHALL have parameter N, default 16, operand/result width in bits (signed two's complement).
REQ-002 SHALL have parameter Q, default 12, fractional bits of operands and result.
REQ-003 SHALL have parameter LEN, default 8, number of operand pairs accumulated per operation (LEN >= 1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  begins an accumulation when in IDLE.
REQ-007 SHALL have port in_valid  input  1  a/b pair present this cycle.
REQ-008 SHALL have port a, b  input  N each  signed Q-format operands.
REQ-009 SHALL have port in_ready  output  1  pair accepted when in_valid && in_ready.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse, result/overflow valid.
REQ-012 SHALL have port q_result  output  N  signed Q-format sum of products.
REQ-013 SHALL have port overflow  output  1  final sum outside N-bit signed range.

Function
REQ-014 SHALL implement FSM IDLE -> ACC -> DRAIN -> DONE -> IDLE.
REQ-015 SHALL, in IDLE with start=1, clear accumulator and pair counter and enter ACC next cycle; start in any other state SHALL be ignored.
REQ-016 SHALL drive in_ready=1 only in ACC; in_valid outside ACC SHALL be ignored.
REQ-017 SHALL, per accepted pair, form the full 2N-bit signed product and shift it arithmetically right by Q (truncation toward minus infinity, e.g. 0xFFFF*0x0001 -> -1 LSB).
REQ-018 SHALL register the shifted product one cycle (product stage), then add it to the accumulator the following cycle.
REQ-019 SHALL size the accumulator 2N-Q+clog2(LEN)+1 bits so no internal wrap is possible.
REQ-020 SHALL leave ACC for DRAIN on the cycle the LEN-th pair is accepted; DRAIN lasts exactly one cycle; DONE lasts exactly one cycle.
REQ-021 SHALL assert out_valid for one cycle in DONE, i.e. 2 cycles after the LEN-th accept edge; bubbles (in_valid=0) in ACC SHALL only stall the counter.
REQ-022 SHALL set overflow=1 with out_valid when the accumulator exceeds [-2^(N-1), 2^(N-1)-1]; exactly -2^(N-1) SHALL NOT flag.
REQ-023 SHALL hold q_result and overflow stable from DONE until the next start is accepted.

Reset
REQ-024 SHALL, on rst=1 at any clock edge including mid-ACC/DRAIN, enter IDLE and clear accumulator, counter, product stage, q_result, overflow, out_valid, in_ready and busy to 0.
REQ-025 SHALL give rst priority over start and in_valid in the same cycle.

Configuration
REQ-026 SHALL support macro FIXED_POINT_MAC_SATURATE_EN: defined -> q_result clamps to 2^(N-1)-1 or -2^(N-1) on overflow; undefined -> q_result is the low N bits of the accumulator (wrap); overflow flag behaves identically in both.

Structure
REQ-027 SHALL place the FSM state encoding and saturation limit constants in shared package fixed_point_pkg.
REQ-028 SHALL implement the multiply/shift/product register as sub-module fixed_point_mul_stage (params N, Q).

Verification
REQ-029 SHALL test: start, 8 pairs a=0x1000 (1.0), b=0x0800 (0.5) back-to-back -> out_valid 2 cycles after 8th accept, q_result=0x4000, overflow=0.
REQ-030 SHALL test: 8 pairs a=b=0x7FFF -> overflow=1; q_result=0x7FFF with SATURATE_EN, 0xFF80 without.
REQ-031 SHALL test: 8 pairs a=0xF000 (-1.0), b=0x1000 -> q_result=0x8000, overflow=0 (exact minimum).
REQ-032 SHALL test: scenario REQ-029 with random in_valid bubbles plus in_valid pulses in IDLE -> identical result, bubbles delay out_valid accordingly.
REQ-033 SHALL test: rst after 3 accepted pairs -> next cycle IDLE, all outputs 0; new start with 8 pairs of REQ-029 -> 0x4000.
REQ-034 SHALL test: start pulsed during ACC and DONE -> ignored, single out_valid per operation.
